// File: rtl/if_id_issue.sv
// IF/ID holding register and issue stage: accepts fetched instructions, splits them
// into decoded fields, and inserts a bubble on a load-use hazard against the EX stage.
module if_id_issue #(
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   if_valid,
    input  logic [31:0]            if_instr,
    input  logic [31:0]            if_pc,
    output logic                   if_ready,
    input  logic                   flush,
    input  logic [6:0]             ex_opcode,
    input  logic [4:0]             ex_rd,
    output logic [6:0]             funct7,
    output logic [4:0]             rs2,
    output logic [4:0]             rs1,
    output logic [2:0]             funct3,
    output logic [4:0]             rd,
    output logic [6:0]             opcode,
    output logic [31:0]            pc,
    output logic                   id_valid,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic                   hold_valid_q, hold_valid_d;
    logic [31:0]            hold_instr_q, hold_instr_d;
    logic [31:0]            hold_pc_q, hold_pc_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [6:0] hold_op;
    logic [4:0] hold_rs1;
    logic [4:0] hold_rs2;
    logic       use_rs1;
    logic       use_rs2;
    logic       hazard;
    logic       issue;

    always_comb begin
        hold_op  = hold_instr_q[6:0];
        hold_rs1 = hold_instr_q[19:15];
        hold_rs2 = hold_instr_q[24:20];

        use_rs1 = !((hold_op == OP_LUI) || (hold_op == OP_AUIPC) || (hold_op == OP_JAL));
        use_rs2 = (hold_op == OP_RTYPE) || (hold_op == OP_STORE) || (hold_op == OP_BRANCH);

        hazard = hold_valid_q && (ex_opcode == OP_LOAD) && (ex_rd != 5'd0) &&
                 ((use_rs1 && (ex_rd == hold_rs1)) || (use_rs2 && (ex_rd == hold_rs2)));
        issue    = hold_valid_q && !hazard && !flush;
        if_ready = flush || !hold_valid_q || issue;

        // Bubble: every field, pc and id_valid are zero unless the held instruction issues.
        {funct7, rs2, rs1, funct3, rd, opcode} = issue ? hold_instr_q : '0;
        pc       = issue ? hold_pc_q : '0;
        id_valid = issue;

        hold_valid_d = hold_valid_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        if (flush) begin
            hold_valid_d = 1'b0;
        end else if (if_valid && if_ready) begin
            hold_valid_d = 1'b1;
            hold_instr_d = if_instr;
            hold_pc_d    = if_pc;
        end else if (issue) begin
            hold_valid_d = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (hazard && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid_q <= 1'b0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            stall_cnt_q  <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_if_id_issue.sv
// Self-checking bench for if_id_issue: directed scenarios plus randomized traffic
// compared against a behavioural model of the hold register.
module tb_if_id_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        flush;
    logic [6:0]  ex_opcode;
    logic [4:0]  ex_rd;
    logic [6:0]  funct7;
    logic [4:0]  rs2;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [31:0] pc;
    logic        id_valid;
    logic [15:0] stall_cnt;

    // Narrow-counter instance so saturation is reached in a few cycles.
    logic        s_if_valid;
    logic [31:0] s_if_instr;
    logic        s_if_ready;
    logic [6:0]  s_funct7;
    logic [4:0]  s_rs2;
    logic [4:0]  s_rs1;
    logic [2:0]  s_funct3;
    logic [4:0]  s_rd;
    logic [6:0]  s_opcode;
    logic [31:0] s_pc;
    logic        s_id_valid;
    logic [3:0]  s_stall_cnt;

    always #5 clk = ~clk;

    if_id_issue #(.STALL_CNT_W(16)) dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_ready(if_ready), .flush(flush), .ex_opcode(ex_opcode), .ex_rd(ex_rd),
        .funct7(funct7), .rs2(rs2), .rs1(rs1), .funct3(funct3), .rd(rd), .opcode(opcode),
        .pc(pc), .id_valid(id_valid), .stall_cnt(stall_cnt)
    );

    if_id_issue #(.STALL_CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .if_valid(s_if_valid), .if_instr(s_if_instr), .if_pc(32'h100),
        .if_ready(s_if_ready), .flush(1'b0), .ex_opcode(7'h03), .ex_rd(5'd5),
        .funct7(s_funct7), .rs2(s_rs2), .rs1(s_rs1), .funct3(s_funct3), .rd(s_rd),
        .opcode(s_opcode), .pc(s_pc), .id_valid(s_id_valid), .stall_cnt(s_stall_cnt)
    );

    int unsigned tests  = 0;
    int unsigned failed = 0;
    bit          chk_en = 1'b0;

    // Model state: what instruction is waiting in the stage, and the stall tally.
    bit          m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    int unsigned m_cnt;

    // Observed outputs from the most recent step, for directed checks.
    logic        o_rdy, o_idv;
    logic [31:0] o_fields, o_pc;
    logic [15:0] o_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_hazard(input logic [6:0] eo, input logic [4:0] er);
        logic [6:0] op;
        bit reads1, reads2;
        op     = m_instr[6:0];
        reads1 = !(op inside {7'h37, 7'h17, 7'h6F});
        reads2 = op inside {7'h33, 7'h23, 7'h63};
        return m_valid && (eo == 7'h03) && (er != 0) &&
               ((reads1 && er == m_instr[19:15]) || (reads2 && er == m_instr[24:20]));
    endfunction

    task automatic step(input logic r, input logic v, input logic [31:0] ins, input logic [31:0] p,
                        input logic fl, input logic [6:0] eo, input logic [4:0] er);
        bit haz, iss, rdy;
        reset = r; if_valid = v; if_instr = ins; if_pc = p; flush = fl; ex_opcode = eo; ex_rd = er;
        #2;
        haz = model_hazard(eo, er);
        iss = m_valid && !haz && !fl;
        rdy = fl || !m_valid || iss;
        o_rdy = if_ready; o_idv = id_valid; o_pc = pc; o_cnt = stall_cnt;
        o_fields = {funct7, rs2, rs1, funct3, rd, opcode};
        if (chk_en) begin
            chk("if_ready",  {31'd0, if_ready}, {31'd0, rdy});
            chk("id_valid",  {31'd0, id_valid}, {31'd0, iss});
            chk("fields",    o_fields, iss ? m_instr : 32'd0);
            chk("pc",        pc, iss ? m_pc : 32'd0);
            chk("stall_cnt", {16'd0, stall_cnt}, m_cnt);
        end
        @(posedge clk);
        if (r) begin
            m_valid = 0; m_instr = 0; m_pc = 0; m_cnt = 0;
        end else begin
            if (haz && !fl && m_cnt < 65535) m_cnt++;
            if (fl) m_valid = 0;
            else if (v && rdy) begin m_valid = 1; m_instr = ins; m_pc = p; end
            else if (iss) m_valid = 0;
        end
        #1;
    endtask

    initial begin
        logic [6:0]  pool [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
        logic [31:0] ins, p;
        logic        v;
        s_if_valid = 1'b0; s_if_instr = 32'h00528333;
        @(posedge clk); #1;

        // Reset with fetch active: stage stays empty.
        step(1, 1, 32'h11111111, 32'h40, 0, 0, 0);
        chk_en = 1'b1;
        step(1, 1, 32'h11111111, 32'h40, 0, 0, 0);
        step(0, 0, 32'h0, 32'h0, 0, 0, 0);
        chk("rst_ready", {31'd0, o_rdy}, 32'd1);
        chk("rst_cnt", {16'd0, o_cnt}, 32'd0);

        // Streaming back-to-back.
        step(0, 1, 32'h002081B3, 32'h0, 0, 0, 0);
        step(0, 1, 32'h00000013, 32'h4, 0, 0, 0);
        chk("stream1_fields", o_fields, 32'h002081B3);
        chk("stream1_ready", {31'd0, o_rdy}, 32'd1);
        step(0, 0, 32'h0, 32'h0, 0, 0, 0);
        chk("stream2_pc", o_pc, 32'h4);

        // Load-use on rs1/rs2 = x5.
        step(0, 1, 32'h00528333, 32'h8, 0, 0, 0);
        step(0, 1, 32'h00000013, 32'hC, 0, 7'h03, 5'd5);
        chk("lu_bubble", {30'd0, o_idv, o_rdy}, 32'd0);
        step(0, 0, 32'h00000013, 32'hC, 0, 7'h00, 5'd5);
        chk("lu_cnt", {16'd0, o_cnt}, 32'd1);
        chk("lu_issue", o_fields, 32'h00528333);

        // No false hazards.
        step(0, 1, 32'h000052B7, 32'h10, 0, 0, 0);
        step(0, 1, 32'h00528293, 32'h14, 0, 7'h03, 5'd0);
        chk("lui_issue", {31'd0, o_idv}, 32'd1);
        step(0, 1, 32'h00500313, 32'h18, 0, 7'h03, 5'd5);
        chk("itype_stall", {31'd0, o_idv}, 32'd0);
        step(0, 1, 32'h00500313, 32'h18, 0, 7'h00, 5'd0);
        step(0, 0, 32'h0, 32'h0, 0, 7'h03, 5'd5);
        chk("addi_x0_issue", {31'd0, o_idv}, 32'd1);

        // Flush during a stall.
        step(0, 1, 32'h00528333, 32'h20, 0, 0, 0);
        step(0, 1, 32'h00000013, 32'h24, 0, 7'h03, 5'd5);
        step(0, 1, 32'h00000013, 32'h24, 1, 7'h03, 5'd5);
        chk("flush_ready", {30'd0, o_idv, o_rdy}, 32'd1);
        step(0, 0, 32'h0, 32'h0, 0, 7'h03, 5'd5);
        chk("flush_empty", {31'd0, o_idv}, 32'd0);

        // Reset mid-stall.
        step(0, 1, 32'h00528333, 32'h30, 0, 0, 0);
        step(0, 0, 32'h0, 32'h0, 0, 7'h03, 5'd5);
        step(1, 0, 32'h0, 32'h0, 0, 7'h03, 5'd5);
        step(0, 0, 32'h0, 32'h0, 0, 7'h03, 5'd5);
        chk("rst_stall_idle", {15'd0, o_cnt, o_idv}, 32'd0);

        // Randomized traffic; fetch holds its word while not accepted.
        v = 0; ins = 0; p = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!(v && !o_rdy)) begin
                v   = ($urandom_range(0, 9) < 7);
                ins = $urandom;
                ins[6:0]   = pool[$urandom_range(0, 8)];
                ins[11:7]  = 5'($urandom_range(0, 3));
                ins[19:15] = 5'($urandom_range(0, 3));
                ins[24:20] = 5'($urandom_range(0, 3));
                p = $urandom;
            end
            step(($urandom_range(0, 99) == 0), v, ins, p, ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 1) == 1) ? 7'h03 : 7'($urandom), 5'($urandom_range(0, 3)));
        end

        // Saturation on the 4-bit instance: continuous hazard on x5.
        s_if_valid = 1'b1;
        @(posedge clk); #1;
        s_if_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("sat_count10", {28'd0, s_stall_cnt}, 32'd10);
        repeat (30) @(posedge clk);
        #1;
        chk("sat_max", {28'd0, s_stall_cnt}, 32'hF);
        chk("sat_bubble", {31'd0, s_id_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
